fpu_issue: RTL and testbench

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_pkg.sv | 8 +
 rtl/fpu_issue.sv | 126 ++++++++++++
 tb/tb_fpu_issue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcode encoding, issue FSM states and FPU opcode width
package fpu_pkg;
    localparam int OPC_W = 8;
    typedef enum logic [2:0] {
        OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT, OP_FTOI, OP_ITOF, OP_FABS
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/fpu_issue.sv
// fpu_issue: accepts one CPU FP request, pulses a one-hot opcode to the FPU, waits for its result with a timeout, and holds a writeback until the register file takes it
//   req_*  : CPU request handshake (op, rd, operands)
//   fpu_*  : one-hot opcode/operands and active-low reset to the FPU, result back
//   wb_*   : writeback to the register file (wb_err flags an abandoned request)
//   busy   : high whenever not IDLE
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [4:0]       req_rd,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    output logic [OPC_W-1:0] fpu_opcode,
    output logic [31:0]      fpu_x1,
    output logic [31:0]      fpu_x2,
    output logic             fpu_rstn,
    input  logic [31:0]      fpu_y,
    input  logic             fpu_ovf,
    input  logic             fpu_unf,
    input  logic             fpu_out_valid,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             wb_ovf,
    output logic             wb_unf,
    output logic             wb_err,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   x1_q, x1_d, x2_q, x2_d, wb_data_q, wb_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wb_ovf_q, wb_ovf_d, wb_unf_q, wb_unf_d, wb_err_q, wb_err_d;
    logic          timeout;
    // cnt_q counts completed WAIT cycles, so TIMEOUT-1 marks the last allowed one; a late result still wins
    assign timeout = (state_q == S_WAIT) && !fpu_out_valid && (cnt_q == CW'(TIMEOUT - 1));
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_ovf_d  = wb_ovf_q;
        wb_unf_d  = wb_unf_q;
        wb_err_d  = wb_err_q;
        case (state_q)
            S_IDLE: if (req_valid && req_ready) begin
                state_d = S_ISSUE;
                op_d    = op_e'(req_op);
                rd_d    = req_rd;
                x1_d    = req_x1;
                x2_d    = req_x2;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (fpu_out_valid) begin
                    state_d   = S_DONE;
                    wb_data_d = fpu_y;
                    wb_ovf_d  = fpu_ovf;
                    wb_unf_d  = fpu_unf;
                    wb_err_d  = 1'b0;
                end else if (timeout) begin
                    state_d   = S_DONE;
                    wb_data_d = '0;
                    wb_ovf_d  = 1'b0;
                    wb_unf_d  = 1'b0;
                    wb_err_d  = 1'b1;
                end
            end
            S_DONE: if (wb_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_FADD;
            rd_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_ovf_q  <= 1'b0;
            wb_unf_q  <= 1'b0;
            wb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_ovf_q  <= wb_ovf_d;
            wb_unf_q  <= wb_unf_d;
            wb_err_q  <= wb_err_d;
        end
    end
    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign fpu_opcode = (state_q == S_ISSUE) ? OPC_W'(1) << op_q : '0;
    assign fpu_x1     = (state_q == S_ISSUE || state_q == S_WAIT) ? x1_q : '0;
    assign fpu_x2     = (state_q == S_ISSUE || state_q == S_WAIT) ? x2_q : '0;
    assign fpu_rstn   = !rst && !timeout;
    assign wb_valid   = state_q == S_DONE;
    assign wb_rd      = rd_q;
    assign wb_data    = wb_data_q;
    assign wb_ovf     = wb_ovf_q;
    assign wb_unf     = wb_unf_q;
    assign wb_err     = wb_err_q;
    assign busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: scoreboard bench for fpu_issue with a latency-programmable stub FPU
module tb_fpu_issue;
    import fpu_pkg::*;
    localparam int TO = 64;
    typedef struct {logic [4:0] rd; logic [31:0] data; logic ovf, unf, err;} wb_t;
    typedef struct {logic [7:0] opc; logic [31:0] x1, x2;} iss_t;
    logic        sys_clk = 0, rst = 1, req_valid = 0, req_ready;
    logic [2:0]  req_op = 0;
    logic [4:0]  req_rd = 0;
    logic [31:0] req_x1 = 0, req_x2 = 0;
    logic [7:0]  fpu_opcode;
    logic [31:0] fpu_x1, fpu_x2;
    logic        fpu_rstn;
    logic [31:0] fpu_y = 0;
    logic        fpu_ovf = 0, fpu_unf = 0, fpu_out_valid = 0;
    logic        wb_valid, wb_ready = 1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ovf, wb_unf, wb_err, busy;
    int          checks = 0, failures = 0, cyc = 0, rstn_pulses = 0;
    int          stub_lat = 0;
    logic [31:0] stub_y = 0;
    logic        stub_ovf = 0, stub_unf = 0, stub_wb = 0;
    wb_t         exp_wb[$];
    iss_t        exp_iss[$];
    int          exp_rise[$];

    fpu_issue #(.TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_x1(req_x1), .req_x2(req_x2),
        .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_rstn(fpu_rstn),
        .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf), .fpu_out_valid(fpu_out_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_ovf(wb_ovf), .wb_unf(wb_unf), .wb_err(wb_err), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=present required=absent", name);
    endtask

    // stub FPU: checks the issued opcode/operands and answers after stub_lat cycles (0 = never)
    initial begin
        iss_t e;
        forever begin
            @(negedge sys_clk);
            if (fpu_opcode != 0) begin
                if (exp_iss.size() == 0) unexpected("opcode_unexpected");
                else begin
                    e = exp_iss.pop_front();
                    chk("fpu_opcode", 32'(fpu_opcode), 32'(e.opc));
                    chk("fpu_x1", fpu_x1, e.x1);
                    chk("fpu_x2", fpu_x2, e.x2);
                end
                if (stub_wb) exp_rise.push_back(cyc + (stub_lat != 0 ? stub_lat : TO) + 1);
                if (stub_lat != 0) begin
                    repeat (stub_lat) @(posedge sys_clk);
                    #1;
                    fpu_out_valid = 1; fpu_y = stub_y; fpu_ovf = stub_ovf; fpu_unf = stub_unf;
                    @(posedge sys_clk);
                    #1;
                    fpu_out_valid = 0; fpu_y = 0; fpu_ovf = 0; fpu_unf = 0;
                end
            end
        end
    end

    initial begin
        logic [7:0] prev;
        prev = 0;
        forever begin
            @(negedge sys_clk);
            if (prev != 0) chk("opcode_one_cycle", 32'(fpu_opcode), 0);
            prev = fpu_opcode;
        end
    end

    initial forever begin
        @(negedge sys_clk);
        if (!rst && !fpu_rstn) rstn_pulses++;
    end

    // writeback monitor: latency on rising wb_valid, stability while held, fields on handshake
    initial begin
        wb_t         e;
        logic        pv, po, pu, pe;
        logic [31:0] pd;
        logic [4:0]  prd;
        int          r;
        pv = 0; po = 0; pu = 0; pe = 0; pd = 0; prd = 0;
        forever begin
            @(negedge sys_clk);
            if (wb_valid && !pv) begin
                if (exp_rise.size() == 0) unexpected("wb_valid_unexpected");
                else begin
                    r = exp_rise.pop_front();
                    chk("wb_latency", 32'(cyc), 32'(r));
                end
            end
            if (wb_valid && pv) begin
                chk("wb_stable_data", wb_data, pd);
                chk("wb_stable_fields", {24'd0, wb_rd, wb_ovf, wb_unf, wb_err}, {24'd0, prd, po, pu, pe});
            end
            if (wb_valid && wb_ready) begin
                if (exp_wb.size() == 0) unexpected("wb_handshake_unexpected");
                else begin
                    e = exp_wb.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                    chk("wb_flags", {29'd0, wb_ovf, wb_unf, wb_err}, {29'd0, e.ovf, e.unf, e.err});
                end
            end
            pv = wb_valid; pd = wb_data; prd = wb_rd; po = wb_ovf; pu = wb_unf; pe = wb_err;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] x1, input logic [31:0] x2,
                         input int lat, input logic [31:0] y, input logic ovf, input logic unf, input logic ewb);
        wb_t  w;
        iss_t s;
        int   n;
        stub_lat = lat; stub_y = y; stub_ovf = ovf; stub_unf = unf; stub_wb = ewb;
        s.opc = 8'(1 << op); s.x1 = x1; s.x2 = x2;
        exp_iss.push_back(s);
        w.rd = rd;
        if (lat != 0) begin w.data = y; w.ovf = ovf; w.unf = unf; w.err = 0; end
        else begin w.data = 0; w.ovf = 0; w.unf = 0; w.err = 1; end
        if (ewb) exp_wb.push_back(w);
        @(posedge sys_clk);
        #1;
        n = 0;
        while (!req_ready && n < 200) begin @(posedge sys_clk); #1; n++; end
        chk("req_ready_wait", 32'(req_ready), 1);
        req_valid = 1; req_op = op; req_rd = rd; req_x1 = x1; req_x2 = x2;
        @(posedge sys_clk);
        #1;
        req_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin @(posedge sys_clk); #1; n++; end
        chk("idle_reached", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_fpu_rstn", 32'(fpu_rstn), 0);
        chk("rst_opcode", 32'(fpu_opcode), 0);
        chk("rst_x1", fpu_x1, 0);
        chk("rst_x2", fpu_x2, 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_fields", {24'd0, wb_rd, wb_ovf, wb_unf, wb_err}, 0);
        rst = 0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 1);
        chk("idle_fpu_rstn", 32'(fpu_rstn), 1);

        issue(OP_FADD, 5'd1, 32'h3F800000, 32'h40000000, 2, 32'h40400000, 0, 0, 1);
        wait_idle();
        issue(OP_FABS, 5'd2, 32'hBF800000, 32'h00000000, 1, 32'h3F800000, 0, 0, 1);
        wait_idle();
        issue(OP_FMUL, 5'd3, 32'h7F000000, 32'h7F000000, 4, 32'h7F800000, 1, 0, 1);
        wait_idle();

        p0 = rstn_pulses;
        issue(OP_FSQRT, 5'd4, 32'h40800000, 32'h00000000, 0, 0, 0, 0, 1);
        wait_idle();
        chk("timeout_rstn_cycles", 32'(rstn_pulses - p0), 1);

        p0 = rstn_pulses;
        issue(OP_FTOI, 5'd6, 32'h40400000, 32'h00000000, TO, 32'h00000003, 0, 1, 1);
        wait_idle();
        chk("late_result_no_rstn", 32'(rstn_pulses - p0), 0);

        wb_ready = 0;
        issue(OP_ITOF, 5'd7, 32'h00000005, 32'h00000000, 3, 32'h40A00000, 0, 0, 1);
        n = 0;
        while (!wb_valid && n < 50) begin @(posedge sys_clk); #1; n++; end
        chk("bp_wb_valid", 32'(wb_valid), 1);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1; req_op = 3'(OP_FADD); req_rd = 5'd31; req_x1 = 32'h1; req_x2 = 32'h2;
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_busy", 32'(busy), 1);
            @(posedge sys_clk);
            #1;
        end
        req_valid = 0;
        wb_ready = 1;
        @(posedge sys_clk);
        #1;
        chk("bp_back_idle", 32'(busy), 0);
        @(posedge sys_clk);
        #1;
        chk("bp_no_accept", 32'(busy), 0);

        issue(OP_FDIV, 5'd8, 32'h40400000, 32'h3F800000, 0, 0, 0, 0, 0);
        repeat (10) @(posedge sys_clk);
        #1;
        chk("mid_wait_busy", 32'(busy), 1);
        rst = 1;
        #1;
        chk("mid_wait_rst_fpu_rstn", 32'(fpu_rstn), 0);
        @(posedge sys_clk);
        #1;
        rst = 0;
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_wb_valid", 32'(wb_valid), 0);
        chk("post_rst_opcode", 32'(fpu_opcode), 0);
        repeat (5) @(posedge sys_clk);
        issue(OP_FSUB, 5'd9, 32'h40400000, 32'h3F800000, 3, 32'h40000000, 0, 0, 1);
        wait_idle();

        repeat (5) @(posedge sys_clk);
        #1;
        chk("queues_drained", 32'(exp_wb.size() + exp_iss.size() + exp_rise.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
